apb_master: RTL
===============

Name: apb_master

Overview:
- APB requester that sits directly upstream of the APB slave RAM and of any other APB slaves on the bus.
- Accepts single read/write commands from a valid/ready request port and runs the APB SETUP -> ACCESS sequence on the bus.
- Decodes one slave select from the top address bit.
- Returns read data, or a timeout error, on a valid/ready response port. One transaction outstanding at a time.

Parameters:
- ADDR_W, 16, width of req_addr and paddr
- DATA_W, 16, width of write/read data
- TIMEOUT, 15, maximum ACCESS cycles without pready before abort (1..255)

Ports:
- pclk  in  1  bus clock; all logic rising-edge
- preset  in  1  asynchronous active-low reset
- req_valid  in  1  command present
- req_ready  out  1  command accepted this cycle when both high
- req_write  in  1  1=write, 0=read
- req_addr  in  ADDR_W  target address
- req_wdata  in  DATA_W  write data
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when both high
- rsp_rdata  out  DATA_W  read data (0 for writes/errors)
- rsp_err  out  1  transaction timed out
- psel  out  2  one-hot slave select; bit = paddr[ADDR_W-1]
- penable  out  1  APB enable
- pwrite  out  1  APB direction
- paddr  out  ADDR_W  APB address
- pwdata  out  DATA_W  APB write data
- prdata  in  DATA_W  APB read data
- pready  in  1  slave completion

Behaviour:
- Reset (preset=0, asynchronous):
  - state=IDLE; psel=0, penable=0, pwrite=0, paddr=0, pwdata=0.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0; timeout counter=0.
  - req_ready=0 while preset is low.
- States: IDLE, SETUP, ACCESS, RESP. Encoding lives in the package; any other encoding returns to IDLE next cycle.
- IDLE:
  - req_ready=1 (combinational, only in IDLE).
  - On req_valid: register write/addr/wdata onto pwrite/paddr/pwdata and go to SETUP.
- SETUP (exactly 1 cycle): psel[paddr[ADDR_W-1]]=1, penable=0, then go to ACCESS.
- ACCESS:
  - psel held, penable=1; paddr/pwrite/pwdata stable throughout.
  - Each cycle, sample pready at the rising edge:
    - pready=1: capture prdata into rsp_rdata (write: rsp_rdata=0), rsp_err=0, go to RESP.
    - pready=0: increment the timeout counter. When the counter reaches TIMEOUT, go to RESP with rsp_err=1 and rsp_rdata=0.
  - Counter clears on entry to SETUP.
- RESP:
  - psel=0, penable=0, rsp_valid=1.
  - Hold rsp_rdata and rsp_err until rsp_ready=1, then go to IDLE.
  - Bus outputs paddr/pwrite/pwdata keep their last values; no requirement beyond psel=0.
- Latency:
  - Zero-wait slave: req accepted cycle 0, SETUP cycle 1, ACCESS cycle 2 with pready.
  - rsp_valid first high in cycle 3.
  - With rsp_ready held high, the next req is accepted in cycle 4.
  - Each slave wait state adds 1 cycle.
- Boundary conditions:
  - req_valid with no ready: the command is not captured; req_* may change freely.
  - pready high during IDLE/SETUP/RESP: ignored.
  - pready on the same cycle the counter would hit TIMEOUT: pready wins, rsp_err=0.
  - Reset mid-ACCESS: bus deasserts immediately, the transaction is lost, no response is produced.
  - Address top bit selects psel[1] or psel[0]; exactly one bit is high in SETUP/ACCESS, never both.
  - Counter width is 8 bits and never wraps; it saturates at TIMEOUT.

Decomposition:
- Package apb_pkg:
  - state enum (IDLE/SETUP/ACCESS/RESP)
  - localparams for the default ADDR_W/DATA_W
  - an apb_req_t struct (write, addr, wdata)
- One natural sub-module: apb_timeout_cnt, an 8-bit clear/enable counter with a saturating expired flag.
- Everything else is flat.

Test Plan:
- Write 0x1234 to 0x0010 against the RAM with zero wait states:
  - psel=01 in cycle 1, penable=1 in cycle 2.
  - rsp_valid in cycle 3 with rsp_err=0 and rsp_rdata=0.
- Read back from 0x0010: rsp_rdata=0x1234, rsp_err=0, rsp_valid in cycle 3 after acceptance.
- Slave with 2 wait states (pready high on the 3rd ACCESS cycle), read of 0x8004:
  - psel=10.
  - Exactly 3 cycles with penable=1.
  - rsp_rdata equals prdata on the pready cycle.
- pready tied low, TIMEOUT=15:
  - penable high for exactly 15 cycles, then psel=0.
  - rsp_err=1, rsp_rdata=0.
- rsp_ready held low for 5 cycles after a read:
  - rsp_valid and rsp_rdata stable throughout.
  - req_ready=0; a pending req_valid is accepted only in the cycle after rsp_ready.
- Assert preset low during ACCESS:
  - psel, penable and rsp_valid drop to 0 asynchronously.
  - After release, req_ready=1 and no stale response appears.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and defaults for the APB requester slice.
package apb_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;
    localparam int CNT_W      = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    typedef struct packed {
        logic                  write;
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] wdata;
    } apb_req_t;

endpackage

// File: rtl/apb_master_if.sv
// Request/response handshake plus APB bus, as seen by the requester (master)
// and by everything around it (slave).
interface apb_master_if
    import apb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    logic [1:0]        psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready, prdata, pready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               psel, penable, pwrite, paddr, pwdata
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready, prdata, pready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               psel, penable, pwrite, paddr, pwdata
    );
endinterface

// File: rtl/apb_timeout_cnt.sv
// 8-bit wait-state counter; saturates at LIMIT, flags the increment that reaches it.
module apb_timeout_cnt
    import apb_pkg::*;
#(
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic last,
    output logic expired
);
    localparam logic [CNT_W-1:0] LIM = CNT_W'(LIMIT);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && cnt != LIM)
            cnt <= cnt + 1'b1;
    end

    // "last" means this enabled increment is the one that lands on LIMIT.
    assign last    = (cnt == LIM - 1'b1);
    assign expired = (cnt == LIM);
endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB requester: valid/ready command in, SETUP -> ACCESS
// on the bus, read data or timeout error out on a valid/ready response.
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 15
) (
    input  logic          pclk,
    input  logic          preset,
    apb_master_if.master  bus
);
    state_t            state_q, state_d;
    logic              write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    logic accept;
    logic cnt_en, cnt_last, cnt_expired;
    logic timeout_hit;
    logic [1:0] sel;

    assign accept      = bus.req_valid && bus.req_ready;
    assign cnt_en      = (state_q == ACCESS) && !bus.pready;
    // pready is checked first in the FSM, so a same-cycle pready beats the timeout.
    assign timeout_hit = cnt_en && (cnt_last || cnt_expired);

    apb_timeout_cnt #(.LIMIT(TIMEOUT)) u_tmo (
        .clk     (pclk),
        .rst_n   (preset),
        .clr     (accept),
        .en      (cnt_en),
        .last    (cnt_last),
        .expired (cnt_expired)
    );

    always_ff @(posedge pclk or negedge preset) begin
        if (!preset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.req_valid) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (bus.pready || timeout_hit) state_d = RESP;
            RESP:    if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                write_q <= bus.req_write;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
            end
            if (state_q == ACCESS) begin
                if (bus.pready) begin
                    rdata_q <= write_q ? '0 : bus.prdata;
                    err_q   <= 1'b0;
                end else if (timeout_hit) begin
                    rdata_q <= '0;
                    err_q   <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        sel = 2'b00;
        if (state_q == SETUP || state_q == ACCESS)
            sel[addr_q[ADDR_W-1]] = 1'b1;
    end

    // Bus strobes decode straight from state so an async reset drops them at once.
    assign bus.req_ready = preset && (state_q == IDLE);
    assign bus.psel      = sel;
    assign bus.penable   = (state_q == ACCESS);
    assign bus.pwrite    = write_q;
    assign bus.paddr     = addr_q;
    assign bus.pwdata    = wdata_q;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
endmodule
